skew_feeder: RTL and testbench



---
 rtl/skew_feeder.sv | 135 +++++++++++++
 tb/tb_skew_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/skew_feeder.sv
// skew_feeder: diagonal input skewer for the systolic matrix-multiply array.
// Takes one tile of ROWS vectors (CH signed lanes of BITS bits) over a
// valid/ready handshake. It emits ROWS+CH-1 steps in which lane c is delayed
// by d(c) steps. Zeros are padded before and after the tile data.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a tile (honoured only when idle)
//   in_valid/ready  input handshake; in_ready mirrors out_ready while loading
//   din             input vector, lane c at din[c]
//   out_ready       downstream accepts a step; low stalls the feeder
//   out_valid       dout was updated by a step on the previous edge
//   dout            skewed output vector
//   busy            a tile is in progress
//   done            one-cycle pulse alongside the final step's out_valid
module skew_feeder #(
  parameter int unsigned BITS     = 8,
  parameter int unsigned CH       = 8,
  parameter int unsigned ROWS     = 8,
  parameter int unsigned SKEW_DIR = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [CH-1:0][BITS-1:0] din,
  input  logic                          out_ready,
  output logic                          out_valid,
  output logic signed [CH-1:0][BITS-1:0] dout,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned KW = $clog2(ROWS + CH) + 1;
  localparam logic [KW-1:0] K_LOAD_LAST = KW'(ROWS - 1);
  localparam logic [KW-1:0] K_LAST      = KW'(ROWS + CH - 2);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [KW-1:0]           k;
  logic                    step;
  logic                    clear;
  logic                    last_step;
  logic [CH-1:0][BITS-1:0] lane_in;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, handshake and step qualification
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    step      = 1'b0;
    clear     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          clear     = 1'b1;
        end
      end
      LOAD: begin
        in_ready = out_ready;
        step     = in_valid & out_ready;
        if (step && (k == K_LOAD_LAST)) begin
          if (CH == 1) state_nxt = IDLE;
          else         state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        step = out_ready;
        if (step && (k == K_LAST)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign last_step = step && (k == K_LAST);

  // Lanes see tile data while loading and zero padding while draining
  assign lane_in = (state == LOAD) ? din : '0;

  // Step counter and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      out_valid <= step;
      done      <= last_step;
      busy      <= (state_nxt != IDLE);
      if (clear)     k <= '0;
      else if (step) k <= k + KW'(1);
    end
  end

  // Per-lane delay: d(c) shift stages ahead of the output register
  for (genvar c = 0; c < int'(CH); c++) begin : g_lane
    localparam int unsigned D = (SKEW_DIR == 0) ? int'(c) : CH - 1 - int'(c);
    logic [BITS-1:0] q;

    assign dout[c] = q;

    if (D == 0) begin : g_pass
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (step) q <= lane_in[c];
      end
    end else begin : g_sr
      logic [D-1:0][BITS-1:0] sr;

      // Start clears the stages so an earlier tile cannot leak into a new one
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sr <= '0;
          q  <= '0;
        end else if (clear) begin
          sr <= '0;
        end else if (step) begin
          q     <= sr[D-1];
          sr[0] <= lane_in[c];
          for (int unsigned i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder (CH=4, ROWS=3). Two instances share the
// stimulus: dut0 skews with d(c)=c and dut1 skews with d(c)=CH-1-c.
module tb_skew_feeder;

  localparam int unsigned BITS = 8;
  localparam int unsigned CH   = 4;
  localparam int unsigned ROWS = 3;

  typedef logic [CH-1:0][BITS-1:0] vec_t;

  logic clk = 1'b0;
  logic rst, start, in_valid, out_ready;
  vec_t din;
  logic in_ready0, out_valid0, busy0, done0;
  logic in_ready1, out_valid1, busy1, done1;
  vec_t dout0, dout1;

  int checks = 0;
  int errors = 0;

  vec_t xs[ROWS];
  vec_t cap0[16];
  vec_t cap1[16];
  int   cap_n;
  int   done_cyc;
  int   stall_bad;
  logic ov_log[32];
  logic busy_at_done;

  vec_t exp_fwd[6];
  vec_t exp_rev[6];
  vec_t exp_neg[6];
  vec_t exp_sev[6];

  always #5 clk = ~clk;

  skew_feeder #(.BITS(BITS), .CH(CH), .ROWS(ROWS), .SKEW_DIR(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready0),
    .din(din), .out_ready(out_ready), .out_valid(out_valid0), .dout(dout0),
    .busy(busy0), .done(done0)
  );

  skew_feeder #(.BITS(BITS), .CH(CH), .ROWS(ROWS), .SKEW_DIR(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready1),
    .din(din), .out_ready(out_ready), .out_valid(out_valid1), .dout(dout1),
    .busy(busy1), .done(done1)
  );

  // Runs one tile from start: vpat/rpat/spat give in_valid/out_ready/start per
  // cycle. Records beats, the done cycle, and any stall-rule violations.
  task automatic run_tile(input logic [31:0] vpat, input logic [31:0] rpat,
                          input logic [31:0] spat, input int budget);
    int   acc;
    vec_t prev;
    logic rdy;
    acc = 0; cap_n = 0; done_cyc = -1; stall_bad = 0; busy_at_done = 1'bx;
    for (int b = 0; b < 16; b++) begin cap0[b] = 'x; cap1[b] = 'x; end
    for (int b = 0; b < 32; b++) ov_log[b] = 1'bx;
    in_valid = 1'b0; out_ready = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    prev  = dout0;
    for (int i = 0; i < budget && done_cyc < 0; i++) begin
      rdy       = rpat[i];
      out_ready = rdy;
      start     = spat[i];
      in_valid  = vpat[i] && (acc < int'(ROWS));
      din       = xs[(acc < int'(ROWS)) ? acc : 0];
      @(negedge clk);
      if (!rdy && (in_ready0 !== 1'b0)) stall_bad++;
      if (in_valid && in_ready0) acc++;
      @(posedge clk); #1;
      ov_log[i] = out_valid0;
      if (out_valid0 === 1'b1 && cap_n < 16) begin
        cap0[cap_n] = dout0;
        cap1[cap_n] = dout1;
        cap_n++;
      end
      if (!rdy && ((out_valid0 !== 1'b0) || (dout0 !== prev))) stall_bad++;
      prev = dout0;
      if (done0 === 1'b1) begin
        done_cyc     = i;
        busy_at_done = busy0;
      end
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (dout0 !== '0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout0); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done0); end
    checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready0); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_skew_fwd();
    run_tile(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 20);
    checks++; if (cap_n !== 6) begin errors++; $display("FAIL fwd_beats: got %0d expected 6", cap_n); end
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (cap0[b] !== exp_fwd[b]) begin errors++; $display("FAIL fwd_beat%0d: got %h expected %h", b, cap0[b], exp_fwd[b]); end
    end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL fwd_done_cycle: got %0d expected 5", done_cyc); end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL fwd_busy_at_done: got %b expected 0", busy_at_done); end
    @(posedge clk); #1;
    checks++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL fwd_idle_after: got valid=%b busy=%b done=%b expected all 0", out_valid0, busy0, done0);
    end
  endtask

  task automatic test_skew_rev();
    run_tile(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 20);
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (cap1[b] !== exp_rev[b]) begin errors++; $display("FAIL rev_beat%0d: got %h expected %h", b, cap1[b], exp_rev[b]); end
    end
    checks++; if (done1 !== 1'b1) begin errors++; $display("FAIL rev_done: got %b expected 1", done1); end
  endtask

  task automatic test_stall();
    // out_ready low on loop cycles 1,2 (load) and 6,7 (drain)
    run_tile(32'hFFFF_FFFF, ~32'h0000_00C6, 32'h0, 20);
    checks++; if (cap_n !== 6) begin errors++; $display("FAIL stall_beats: got %0d expected 6", cap_n); end
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (cap0[b] !== exp_fwd[b]) begin errors++; $display("FAIL stall_beat%0d: got %h expected %h", b, cap0[b], exp_fwd[b]); end
    end
    checks++; if (done_cyc !== 9) begin errors++; $display("FAIL stall_done_cycle: got %0d expected 9", done_cyc); end
    checks++; if (stall_bad !== 0) begin errors++; $display("FAIL stall_hold: got %0d violations expected 0", stall_bad); end
  endtask

  task automatic test_gaps();
    run_tile(32'h0000_0015, 32'hFFFF_FFFF, 32'h0, 20);
    checks++; if (cap_n !== 6) begin errors++; $display("FAIL gaps_beats: got %0d expected 6", cap_n); end
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (cap0[b] !== exp_fwd[b]) begin errors++; $display("FAIL gaps_beat%0d: got %h expected %h", b, cap0[b], exp_fwd[b]); end
    end
    checks++; if (ov_log[1] !== 1'b0 || ov_log[3] !== 1'b0) begin
      errors++; $display("FAIL gaps_no_valid: got %b,%b expected 0,0", ov_log[1], ov_log[3]);
    end
    checks++; if (done_cyc !== 7) begin errors++; $display("FAIL gaps_done_cycle: got %0d expected 7", done_cyc); end
  endtask

  task automatic test_abort();
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; din = xs[0];
    @(posedge clk); #1;
    din = xs[1];
    @(posedge clk); #1;
    checks++; if (dout0 !== vec_t'({8'd0, 8'd0, 8'd2, 8'd5})) begin
      errors++; $display("FAIL abort_pre_dout: got %h expected 00000205", dout0);
    end
    din = xs[2];
    #2 rst = 1'b1;
    #1;
    checks++; if (dout0 !== '0 || dout1 !== '0) begin errors++; $display("FAIL abort_dout: got %h/%h expected 0", dout0, dout1); end
    checks++; if (out_valid0 !== 1'b0 || busy0 !== 1'b0 || in_ready0 !== 1'b0) begin
      errors++; $display("FAIL abort_ctrl: got valid=%b busy=%b in_ready=%b expected all 0", out_valid0, busy0, in_ready0);
    end
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    for (int j = 0; j < int'(ROWS); j++) xs[j] = {8'hFC, 8'hFD, 8'hFE, 8'hFF};
    run_tile(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 20);
    checks++; if (cap_n !== 6) begin errors++; $display("FAIL abort_beats: got %0d expected 6", cap_n); end
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (cap0[b] !== exp_neg[b]) begin errors++; $display("FAIL abort_beat%0d: got %h expected %h", b, cap0[b], exp_neg[b]); end
    end
  endtask

  task automatic test_back_to_back();
    xs = '{{8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, {8'd12, 8'd11, 8'd10, 8'd9}};
    run_tile(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 20);
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL b2b_first_done: got %0d expected 5", done_cyc); end
    // Next start lands in the done cycle; stray starts mid-tile are ignored
    for (int j = 0; j < int'(ROWS); j++) xs[j] = {8'd7, 8'd7, 8'd7, 8'd7};
    run_tile(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000A, 20);
    checks++; if (cap_n !== 6) begin errors++; $display("FAIL b2b_beats: got %0d expected 6", cap_n); end
    for (int b = 0; b < 6; b++) begin
      checks++;
      if (cap0[b] !== exp_sev[b]) begin errors++; $display("FAIL b2b_beat%0d: got %h expected %h", b, cap0[b], exp_sev[b]); end
    end
    checks++; if (done_cyc !== 5) begin errors++; $display("FAIL b2b_second_done: got %0d expected 5", done_cyc); end
  endtask

  initial begin
    xs = '{{8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, {8'd12, 8'd11, 8'd10, 8'd9}};
    // Beat vectors written {lane3, lane2, lane1, lane0}
    exp_fwd = '{{8'd0, 8'd0, 8'd0, 8'd1}, {8'd0, 8'd0, 8'd2, 8'd5}, {8'd0, 8'd3, 8'd6, 8'd9},
                {8'd4, 8'd7, 8'd10, 8'd0}, {8'd8, 8'd11, 8'd0, 8'd0}, {8'd12, 8'd0, 8'd0, 8'd0}};
    exp_rev = '{{8'd4, 8'd0, 8'd0, 8'd0}, {8'd8, 8'd3, 8'd0, 8'd0}, {8'd12, 8'd7, 8'd2, 8'd0},
                {8'd0, 8'd11, 8'd6, 8'd1}, {8'd0, 8'd0, 8'd10, 8'd5}, {8'd0, 8'd0, 8'd0, 8'd9}};
    exp_neg = '{{8'h00, 8'h00, 8'h00, 8'hFF}, {8'h00, 8'h00, 8'hFE, 8'hFF}, {8'h00, 8'hFD, 8'hFE, 8'hFF},
                {8'hFC, 8'hFD, 8'hFE, 8'h00}, {8'hFC, 8'hFD, 8'h00, 8'h00}, {8'hFC, 8'h00, 8'h00, 8'h00}};
    exp_sev = '{{8'd0, 8'd0, 8'd0, 8'd7}, {8'd0, 8'd0, 8'd7, 8'd7}, {8'd0, 8'd7, 8'd7, 8'd7},
                {8'd7, 8'd7, 8'd7, 8'd0}, {8'd7, 8'd7, 8'd0, 8'd0}, {8'd7, 8'd0, 8'd0, 8'd0}};

    test_reset();
    test_skew_fwd();
    test_skew_rev();
    test_stall();
    test_gaps();
    test_abort();
    test_back_to_back();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
